mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Initiator side of the data-memory port. Accepts load/store requests from the MEM pipeline stage
//  (LW, LBU, LB, SW, SB) and sequences the level-sensitive data memory's address, data and write strobe.
//  Write strobe is guaranteed one-cycle and glitch-free; address/data are stable one cycle before and after it.
//  Returns load data (with LB sign-extension) plus a one-cycle completion pulse. Stalls the stage via req_ready.
// PARAMETERS
//  ADDR_W       16  byte-address width
//  DATA_W       16  data width (word = 2 bytes, little-endian: low byte at addr, high byte at addr+1)
//  STRICT_ALIGN 1   1: word access with addr[0]=1 is rejected with resp_err; 0: issued unmodified
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  reset       in   1       synchronous, active-high
//  req_valid   in   1       request present
//  req_ready   out  1       controller can accept (state IDLE)
//  req_write   in   1       1=store, 0=load
//  req_byte    in   1       1=byte access, 0=word access
//  req_signed  in   1       byte load only: 1=LB sign-extend, 0=LBU zero-extend
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   DATA_W  store data (byte store uses [7:0])
//  resp_valid  out  1       one-cycle completion pulse (loads and stores)
//  resp_err    out  1       qualifies resp_valid: misaligned word under STRICT_ALIGN
//  resp_rdata  out  DATA_W  load result; holds until next successful load completes
//  access_cnt  out  16      count of completed non-error accesses, wraps 0xFFFF->0x0000
//  mem_write   out  1       to memory memWrite
//  mem_byte_en out  1       to memory byte_en
//  mem_addr    out  ADDR_W  to memory address
//  mem_wdata   out  DATA_W  to memory writeData
//  mem_rdata   in   DATA_W  from memory readData (combinational, zero-extended on byte reads)
// BEHAVIOUR
//  - All outputs registered except req_ready (= state==IDLE).
//  - Reset: state IDLE; mem_write, mem_byte_en, resp_valid, resp_err = 0; mem_addr, mem_wdata, resp_rdata,
//    access_cnt = 0. Reset in any state aborts the access: no resp_valid, mem_write low the next cycle.
//  - States: IDLE, RD_ADDR, RD_CAP, WR_SETUP, WR_STROBE, WR_HOLD, ERR.
//  - IDLE, req_valid=1: latch request; mem_addr<=req_addr, mem_byte_en<=req_byte,
//    mem_wdata<=req_byte ? {8'h00,req_wdata[7:0]} : req_wdata.
//    Misaligned word with STRICT_ALIGN=1 -> ERR, memory untouched; else load -> RD_ADDR, store -> WR_SETUP.
//  - Load timing, accept edge ending cycle T: T+1 RD_ADDR (settle), T+2 RD_CAP (mem_rdata sampled at end),
//    T+3 IDLE with resp_valid=1. resp_rdata = word ? mem_rdata : {{8{req_signed & b[7]}}, b}, b = mem_rdata[7:0].
//  - Store: T+1 WR_SETUP (mem_write=0), T+2 WR_STROBE (mem_write=1), T+3 WR_HOLD (mem_write=0),
//    T+4 IDLE with resp_valid=1. mem_addr/mem_wdata/mem_byte_en constant T+1..T+3.
//  - ERR: T+1 ERR, T+2 IDLE with resp_valid=1, resp_err=1; resp_rdata, access_cnt unchanged.
//  - resp_valid is high only for the first IDLE cycle after completion. A new request may be accepted in that
//    same cycle (back-to-back). req_valid outside IDLE is ignored; requester holds it.
//  - access_cnt increments in the cycle resp_valid rises with resp_err=0.
//  - Address arithmetic is ADDR_W-bit; 0xFFFF word access is issued as-is (memory handles addr+1).
// STRUCTURE
//  - Shared header mem_if_defs.vh: state encodings, ADDR_W/DATA_W defaults, byte/word and load/store constants.
//  - Single FSM plus datapath registers; load extension is a small combinational sub-module load_extend
//    (in: rdata, byte, signed; out: result), reused by the writeback stage.
// TESTING
//  1 Memory after reset; LW addr 0x0000 -> resp_valid at T+3, resp_rdata=0x3856, resp_err=0, access_cnt=1.
//  2 LBU 0x0006 -> 0x00DE; LB 0x0006 -> 0xFFDE; LB 0x0004 -> 0x0012.
//  3 SW 0xBEEF @0x0010, then LW 0x0010 -> 0xBEEF; SB 0x77 @0x0011, LW 0x0010 -> 0x77EF;
//    check mem_write high exactly 1 cycle, addr/data stable one cycle before and after.
//  4 STRICT_ALIGN=1, LW 0x0001 -> resp_valid+resp_err at T+2, mem_write never high,
//    resp_rdata and access_cnt unchanged.
//  5 reset asserted during WR_STROBE -> mem_write=0 next cycle, state IDLE, no resp_valid, access_cnt=0.
//  6 req_valid held continuously with alternating LW/SW -> each accepted in resp_valid cycle,
//    no lost or duplicated requests; access_cnt wrap 0xFFFF->0x0000 via forced preload.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory initiator: defaults, access constants, FSM states.
package mem_access_ctrl_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // Access size and direction encodings as seen on req_byte / req_write.
  localparam logic ACC_BYTE = 1'b1;
  localparam logic ACC_WORD = 1'b0;
  localparam logic OP_STORE = 1'b1;
  localparam logic OP_LOAD  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_ADDR   = 3'd1,
    ST_RD_CAP    = 3'd2,
    ST_WR_SETUP  = 3'd3,
    ST_WR_STROBE = 3'd4,
    ST_WR_HOLD   = 3'd5,
    ST_ERR       = 3'd6
  } state_e;

  // A word access is misaligned when it starts on an odd byte address.
  function automatic logic is_misaligned(input logic byte_acc, input logic addr_lsb);
    return (byte_acc == ACC_WORD) && addr_lsb;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Load result formatting: word passes through, byte is zero- or sign-extended from bit 7.
module load_extend #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic              byte_acc,
  input  logic              signed_ext,
  output logic [DATA_W-1:0] result
);

  // Pure combinational extension, shared with the writeback stage.
  always_comb begin
    if (byte_acc) begin
      result = {{(DATA_W-8){signed_ext & rdata[7]}}, rdata[7:0]};
    end else begin
      result = rdata;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the data-memory port: sequences address, data and a single-cycle
// write strobe for a level-sensitive memory, and returns load data with a completion pulse.
//
// Handshake: a request transfers on a rising edge where req_valid=1 and req_ready=1.
// req_ready is high exactly in IDLE; the requester holds req_valid and the request fields
// until that edge. resp_valid is a one-cycle pulse in the first IDLE cycle after an access
// completes, and a new request may transfer in that same cycle.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter bit STRICT_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [15:0]       access_cnt,
  output logic              mem_write,
  output logic              mem_byte_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        dbg_state
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_byte_en_q, mem_byte_en_d;
  logic              mem_write_q, mem_write_d;
  logic              signed_q, signed_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic [15:0]       access_cnt_q, access_cnt_d;
  logic [DATA_W-1:0] ext_result;

  // The latched access size/sign drive the extension so the request bus may change freely.
  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .rdata      (mem_rdata),
    .byte_acc   (mem_byte_en_q),
    .signed_ext (signed_q),
    .result     (ext_result)
  );

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_byte_en_d = mem_byte_en_q;
    signed_d      = signed_q;
    mem_write_d   = 1'b0;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    access_cnt_d  = access_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          mem_addr_d    = req_addr;
          mem_byte_en_d = req_byte;
          signed_d      = req_signed;
          mem_wdata_d   = req_byte ? {{(DATA_W-8){1'b0}}, req_wdata[7:0]} : req_wdata;
          if (STRICT_ALIGN && is_misaligned(req_byte, req_addr[0])) begin
            state_d = ST_ERR;
          end else if (req_write == OP_STORE) begin
            state_d = ST_WR_SETUP;
          end else begin
            state_d = ST_RD_ADDR;
          end
        end
      end
      ST_RD_ADDR: begin
        state_d = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        resp_rdata_d = ext_result;
        resp_valid_d = 1'b1;
        access_cnt_d = access_cnt_q + 16'd1;
        state_d      = ST_IDLE;
      end
      ST_WR_SETUP: begin
        // Strobe is a flop output, so it is glitch-free and exactly one cycle wide.
        mem_write_d = 1'b1;
        state_d     = ST_WR_STROBE;
      end
      ST_WR_STROBE: begin
        state_d = ST_WR_HOLD;
      end
      ST_WR_HOLD: begin
        resp_valid_d = 1'b1;
        access_cnt_d = access_cnt_q + 16'd1;
        state_d      = ST_IDLE;
      end
      ST_ERR: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_byte_en_q <= 1'b0;
      signed_q      <= 1'b0;
      mem_write_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= '0;
      access_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_byte_en_q <= mem_byte_en_d;
      signed_q      <= signed_d;
      mem_write_q   <= mem_write_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_rdata_q  <= resp_rdata_d;
      access_cnt_q  <= access_cnt_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign access_cnt  = access_cnt_q;
  assign mem_write   = mem_write_q;
  assign mem_byte_en = mem_byte_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural level-sensitive byte memory.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic        req_signed = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [15:0] resp_rdata;
  logic [15:0] access_cnt;
  logic        mem_write;
  logic        mem_byte_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] addr_p1;

  mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .STRICT_ALIGN(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_byte    (req_byte),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_rdata  (resp_rdata),
    .access_cnt  (access_cnt),
    .mem_write   (mem_write),
    .mem_byte_en (mem_byte_en),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Memory model: combinational read, write while mem_write is high at the clock edge.
  assign addr_p1 = mem_addr + 16'd1;
  always_comb begin
    if (mem_byte_en) mem_rdata = {8'h00, mem[mem_addr]};
    else             mem_rdata = {mem[addr_p1], mem[mem_addr]};
  end
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr] <= mem_wdata[7:0];
      if (!mem_byte_en) mem[addr_p1] <= mem_wdata[15:8];
    end
  end

  // Driver: issue one request from IDLE and observe until its response or a cycle budget.
  task automatic run_req(input logic w, input logic b, input logic s,
                         input logic [15:0] a, input logic [15:0] d,
                         output int lat, output logic err, output logic [15:0] rd,
                         output int wr_cycles, output int wr_at, output logic stable,
                         output logic [15:0] a_seen, output logic [15:0] d_seen);
    logic be0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_byte = b; req_signed = s;
    req_addr = a; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; err = 1'b0; rd = '0; wr_cycles = 0; wr_at = 0; stable = 1'b1;
    a_seen = mem_addr; d_seen = mem_wdata; be0 = mem_byte_en;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (mem_write) begin wr_cycles++; wr_at = k; end
      if (resp_valid) begin lat = k; err = resp_err; rd = resp_rdata; break; end
      if (mem_addr !== a_seen || mem_wdata !== d_seen || mem_byte_en !== be0) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin bad++; $display("FAIL rst_resp got=%b%b exp=00", resp_valid, resp_err); end
    total++; if (mem_write !== 1'b0 || mem_byte_en !== 1'b0) begin bad++; $display("FAIL rst_mem_ctl got=%b%b exp=00", mem_write, mem_byte_en); end
    total++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin bad++; $display("FAIL rst_mem_bus got=%h/%h exp=0000/0000", mem_addr, mem_wdata); end
    total++; if (resp_rdata !== 16'h0 || access_cnt !== 16'h0) begin bad++; $display("FAIL rst_regs got=%h/%h exp=0000/0000", resp_rdata, access_cnt); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_load_word();
    int lat, wc, wa; logic err, st; logic [15:0] rd, as, ds;
    run_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0, lat, err, rd, wc, wa, st, as, ds);
    total++; if (lat !== 3) begin bad++; $display("FAIL lw_latency got=%0d exp=3", lat); end
    total++; if (rd !== 16'h3856 || err !== 1'b0) begin bad++; $display("FAIL lw_data got=%h err=%b exp=3856 err=0", rd, err); end
    total++; if (access_cnt !== 16'd1) begin bad++; $display("FAIL lw_cnt got=%0d exp=1", access_cnt); end
    total++; if (wc !== 0) begin bad++; $display("FAIL lw_no_write got=%0d exp=0", wc); end
  endtask

  task automatic test_load_byte();
    int lat, wc, wa; logic err, st; logic [15:0] rd, as, ds;
    run_req(1'b0, 1'b1, 1'b0, 16'h0006, 16'h0, lat, err, rd, wc, wa, st, as, ds);
    total++; if (lat !== 3 || rd !== 16'h00DE) begin bad++; $display("FAIL lbu_6 got=%h lat=%0d exp=00de lat=3", rd, lat); end
    run_req(1'b0, 1'b1, 1'b1, 16'h0006, 16'h0, lat, err, rd, wc, wa, st, as, ds);
    total++; if (lat !== 3 || rd !== 16'hFFDE) begin bad++; $display("FAIL lb_6 got=%h lat=%0d exp=ffde lat=3", rd, lat); end
    run_req(1'b0, 1'b1, 1'b1, 16'h0004, 16'h0, lat, err, rd, wc, wa, st, as, ds);
    total++; if (lat !== 3 || rd !== 16'h0012) begin bad++; $display("FAIL lb_4 got=%h lat=%0d exp=0012 lat=3", rd, lat); end
    total++; if (access_cnt !== 16'd4) begin bad++; $display("FAIL lb_cnt got=%0d exp=4", access_cnt); end
  endtask

  task automatic test_store();
    int lat, wc, wa; logic err, st; logic [15:0] rd, as, ds;
    run_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, lat, err, rd, wc, wa, st, as, ds);
    total++; if (lat !== 4 || err !== 1'b0) begin bad++; $display("FAIL sw_latency got=%0d err=%b exp=4 err=0", lat, err); end
    total++; if (wc !== 1 || wa !== 2) begin bad++; $display("FAIL sw_strobe got=%0d@%0d exp=1@2", wc, wa); end
    total++; if (st !== 1'b1 || as !== 16'h0010 || ds !== 16'hBEEF) begin bad++; $display("FAIL sw_bus got=%b %h %h exp=1 0010 beef", st, as, ds); end
    run_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, lat, err, rd, wc, wa, st, as, ds);
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL sw_readback got=%h exp=beef", rd); end
    run_req(1'b1, 1'b1, 1'b0, 16'h0011, 16'h4477, lat, err, rd, wc, wa, st, as, ds);
    total++; if (wc !== 1 || wa !== 2 || st !== 1'b1) begin bad++; $display("FAIL sb_strobe got=%0d@%0d st=%b exp=1@2 st=1", wc, wa, st); end
    total++; if (as !== 16'h0011 || ds !== 16'h0077) begin bad++; $display("FAIL sb_bus got=%h %h exp=0011 0077", as, ds); end
    run_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, lat, err, rd, wc, wa, st, as, ds);
    total++; if (rd !== 16'h77EF) begin bad++; $display("FAIL sb_readback got=%h exp=77ef", rd); end
    total++; if (access_cnt !== 16'd8) begin bad++; $display("FAIL st_cnt got=%0d exp=8", access_cnt); end
  endtask

  task automatic test_misaligned();
    int lat, wc, wa; logic err, st; logic [15:0] rd, as, ds;
    run_req(1'b0, 1'b0, 1'b0, 16'h0001, 16'h0, lat, err, rd, wc, wa, st, as, ds);
    total++; if (lat !== 2 || err !== 1'b1) begin bad++; $display("FAIL mis_lw got=lat%0d err%b exp=lat2 err1", lat, err); end
    total++; if (rd !== 16'h77EF || access_cnt !== 16'd8) begin bad++; $display("FAIL mis_lw_hold got=%h/%0d exp=77ef/8", rd, access_cnt); end
    run_req(1'b1, 1'b0, 1'b0, 16'h0003, 16'h5555, lat, err, rd, wc, wa, st, as, ds);
    total++; if (lat !== 2 || err !== 1'b1 || wc !== 0) begin bad++; $display("FAIL mis_sw got=lat%0d err%b wr%0d exp=lat2 err1 wr0", lat, err, wc); end
    total++; if (mem[3] !== 8'h00 || mem[4] !== 8'h12) begin bad++; $display("FAIL mis_sw_mem got=%h%h exp=1200", mem[4], mem[3]); end
    total++; if (access_cnt !== 16'd8) begin bad++; $display("FAIL mis_cnt got=%0d exp=8", access_cnt); end
  endtask

  task automatic test_cnt_wrap();
    int lat, wc, wa; logic err, st; logic [15:0] rd, as, ds;
    @(negedge clk);
    force dut.access_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.access_cnt_q;
    run_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0, lat, err, rd, wc, wa, st, as, ds);
    total++; if (access_cnt !== 16'h0000 || rd !== 16'h3856) begin bad++; $display("FAIL cnt_wrap got=%h rd=%h exp=0000 rd=3856", access_cnt, rd); end
    run_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0, lat, err, rd, wc, wa, st, as, ds);
    total++; if (access_cnt !== 16'h0001) begin bad++; $display("FAIL cnt_after_wrap got=%h exp=0001", access_cnt); end
  endtask

  task automatic test_back_to_back();
    logic        op_w [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        op_b [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] op_a [6] = '{16'h0030, 16'h0030, 16'h0032, 16'h0032, 16'h0031, 16'h0030};
    logic [15:0] op_d [6] = '{16'h1111, 16'h0000, 16'h2222, 16'h0000, 16'h00AB, 16'h0000};
    logic [15:0] op_e [6] = '{16'h0000, 16'h1111, 16'h0000, 16'h2222, 16'h0000, 16'hAB11};
    logic [15:0] exp_q [$];
    int i = 0;
    int n_resp = 0;
    int late = 0;
    int extra = 0;
    logic rdy;
    logic [15:0] cnt0;
    cnt0 = access_cnt;
    for (int k = 0; k < 6; k++) if (!op_w[k]) exp_q.push_back(op_e[k]);
    @(negedge clk);
    req_valid = 1'b1; req_write = op_w[0]; req_byte = op_b[0]; req_signed = 1'b0;
    req_addr = op_a[0]; req_wdata = op_d[0];
    for (int c = 0; c < 60; c++) begin
      if (resp_valid) begin
        if (resp_err !== 1'b0) begin bad++; $display("FAIL b2b_err resp=%0d got=1 exp=0", n_resp); end
        if (!op_w[n_resp]) begin
          total++;
          if (exp_q.size() == 0 || resp_rdata !== exp_q[0]) begin
            bad++; $display("FAIL b2b_load resp=%0d got=%h exp=%h", n_resp, resp_rdata, op_e[n_resp]);
          end
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        n_resp++;
      end
      if (n_resp == 6) break;
      rdy = req_ready && (i < 6);
      if (rdy && i > 0 && !resp_valid) late++;
      @(posedge clk);
      if (rdy) i++;
      @(negedge clk);
      if (i < 6) begin
        req_write = op_w[i]; req_byte = op_b[i]; req_addr = op_a[i]; req_wdata = op_d[i];
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) extra++;
    end
    total++; if (n_resp !== 6 || i !== 6) begin bad++; $display("FAIL b2b_count got=resp%0d acc%0d exp=resp6 acc6", n_resp, i); end
    total++; if (late !== 0) begin bad++; $display("FAIL b2b_accept_cycle got=%0d exp=0", late); end
    total++; if (extra !== 0) begin bad++; $display("FAIL b2b_extra_resp got=%0d exp=0", extra); end
    total++; if (access_cnt !== cnt0 + 16'd6) begin bad++; $display("FAIL b2b_cnt got=%h exp=%h", access_cnt, cnt0 + 16'd6); end
  endtask

  task automatic test_reset_abort();
    int seen_resp = 0;
    int seen_wr = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 16'h0040; req_wdata = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL abort_strobe got=%b exp=1", mem_write); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (mem_write !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL abort_outputs got=wr%b rv%b exp=wr0 rv0", mem_write, resp_valid); end
    total++; if (dbg_state !== 3'd0 || req_ready !== 1'b1) begin bad++; $display("FAIL abort_state got=%0d rdy=%b exp=0 rdy=1", dbg_state, req_ready); end
    total++; if (access_cnt !== 16'h0) begin bad++; $display("FAIL abort_cnt got=%h exp=0000", access_cnt); end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen_resp++;
      if (mem_write) seen_wr++;
    end
    total++; if (seen_resp !== 0 || seen_wr !== 0) begin bad++; $display("FAIL abort_quiet got=rv%0d wr%0d exp=rv0 wr0", seen_resp, seen_wr); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[0] = 8'h56; mem[1] = 8'h38; mem[4] = 8'h12; mem[6] = 8'hDE;
    test_reset();
    test_load_word();
    test_load_byte();
    test_store();
    test_misaligned();
    test_cnt_wrap();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
